// File: rtl/resp_compactor_pkg.sv
// Shared types and helpers for the response compactor.
package resp_compactor_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StCompare,
    StDone
  } state_e;

  localparam logic [15:0] DEFAULT_POLY = 16'h1021;

  // Beat counter must be able to hold COUNT itself, not just COUNT-1.
  function automatic int unsigned cnt_width(input int unsigned count);
    return (count < 1) ? 1 : $clog2(count + 1);
  endfunction

endpackage

// File: rtl/sig_lfsr_step.sv
// One combinational step of the signature shift register: shift, fold in POLY on MSB carry-out,
// and XOR in the response word.
module sig_lfsr_step #(
  parameter int unsigned       RESP_W = 1,
  parameter int unsigned       SIG_W  = 16,
  parameter logic [SIG_W-1:0]  POLY   = SIG_W'(16'h1021)
) (
  input  logic [SIG_W-1:0]  sig_cur,
  input  logic [RESP_W-1:0] data,
  output logic [SIG_W-1:0]  sig_next
);

  always_comb begin
    sig_next = {sig_cur[SIG_W-2:0], 1'b0}
             ^ (sig_cur[SIG_W-1] ? POLY : '0)
             ^ SIG_W'(data);
  end

endmodule

// File: rtl/resp_compactor.sv
// Response compactor: folds COUNT response beats into a signature and compares it to EXPECTED.
// Optional first-mismatch tracking is enabled by defining RESP_COMPACTOR_FIRST_FAIL_EN.
module resp_compactor
  import resp_compactor_pkg::*;
#(
  parameter int unsigned      RESP_W   = 1,
  parameter int unsigned      COUNT    = 8,
  parameter int unsigned      SIG_W    = 16,
  parameter logic [SIG_W-1:0] POLY     = SIG_W'(DEFAULT_POLY),
  parameter logic [SIG_W-1:0] SEED     = '0,
  parameter logic [SIG_W-1:0] EXPECTED = '0,
  localparam int unsigned     CNT_W    = cnt_width(COUNT),
  localparam int unsigned     IDX_W    = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RESP_W-1:0] in_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
`ifdef RESP_COMPACTOR_FIRST_FAIL_EN
  input  logic [RESP_W-1:0] exp_data,
  output logic              fail_seen,
  output logic [IDX_W-1:0]  fail_idx,
`endif
  output logic [SIG_W-1:0]  signature
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [SIG_W-1:0]   sig_step;
  logic               pass_q, pass_d;
  logic               start_run;
  logic               accept;
  logic               fail_block;

  sig_lfsr_step #(
    .RESP_W (RESP_W),
    .SIG_W  (SIG_W),
    .POLY   (POLY)
  ) u_step (
    .sig_cur  (sig_q),
    .data     (in_data),
    .sig_next (sig_step)
  );

  assign start_run = start && ((state_q == StIdle) || (state_q == StDone));
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_run) begin
          state_d = StCollect;
          sig_d   = SEED;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      StCollect: begin
        if (in_valid) begin
          sig_d = sig_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(COUNT - 1)) state_d = StCompare;
        end
      end
      StCompare: begin
        pass_d  = (sig_q == EXPECTED) && !fail_block;
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sig_q   <= SEED;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
    end
  end

`ifdef RESP_COMPACTOR_FIRST_FAIL_EN
  logic             fail_seen_q, fail_seen_d;
  logic [IDX_W-1:0] fail_idx_q, fail_idx_d;

  // Only the first mismatching beat is recorded; later ones leave the index alone.
  always_comb begin
    fail_seen_d = fail_seen_q;
    fail_idx_d  = fail_idx_q;
    if (start_run) begin
      fail_seen_d = 1'b0;
      fail_idx_d  = '0;
    end else if (accept && !fail_seen_q && (in_data != exp_data)) begin
      fail_seen_d = 1'b1;
      fail_idx_d  = IDX_W'(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_seen_q <= 1'b0;
      fail_idx_q  <= '0;
    end else begin
      fail_seen_q <= fail_seen_d;
      fail_idx_q  <= fail_idx_d;
    end
  end

  assign fail_seen  = fail_seen_q;
  assign fail_idx   = fail_idx_q;
  assign fail_block = fail_seen_q;
`else
  assign fail_block = 1'b0;
`endif

  assign in_ready  = (state_q == StCollect);
  assign busy      = (state_q == StCollect) || (state_q == StCompare);
  assign done      = (state_q == StDone);
  assign pass      = done && pass_q;
  assign signature = sig_q;

endmodule
